// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai31_exerciser.sv
// Exhaustive 16-vector exerciser for an OAI31 cell: drives {A1,A2,A3,B}, lets each vector
// settle, checks ZN against ~((A1|A2|A3)&B) and records a saturating error count and first failure.
module gf180mcu_fd_sc_mcu9t5v0__oai31_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             B,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             FAIL_VLD,
  output logic [3:0]       FAIL_VEC,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_idx, w_idx_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic [3:0]         r_stim, w_stim_nxt;
  logic [ERR_W-1:0]   r_err, w_err_nxt;
  logic               r_fvld, w_fvld_nxt;
  logic [3:0]         r_fvec, w_fvec_nxt;
  logic               w_exp;
  logic               w_mismatch;

  // Supply pins carry no function; folding them into a named sink keeps them connected.
  wire w_unused_supply = VDD ^ VSS;

  assign w_exp      = ~((r_idx[3] | r_idx[2] | r_idx[1]) & r_idx[0]);
  // Identity compare so an X or Z on ZN is treated as a mismatch.
  assign w_mismatch = !(ZN === w_exp);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_fvld_nxt  = r_fvld;
    w_fvec_nxt  = r_fvec;
    case (r_state)
      StIdle, StDone: begin
        if (START) begin
          w_idx_nxt   = 4'd0;
          w_err_nxt   = '0;
          w_fvld_nxt  = 1'b0;
          w_fvec_nxt  = 4'd0;
          w_cnt_nxt   = LP_SETTLE;
          w_state_nxt = StSettle;
        end
      end
      StSettle: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = StSample;
        end
      end
      StSample: begin
        if (w_mismatch) begin
          if (r_err != {ERR_W{1'b1}}) w_err_nxt = r_err + 1'b1;
          if (!r_fvld) begin
            w_fvld_nxt = 1'b1;
            w_fvec_nxt = r_idx;
          end
        end
        if (r_idx == 4'd15) begin
          w_state_nxt = StDone;
        end else begin
          w_idx_nxt   = r_idx + 4'd1;
          w_cnt_nxt   = LP_SETTLE;
          w_state_nxt = StSettle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    w_stim_nxt = (w_state_nxt == StSettle || w_state_nxt == StSample) ? w_idx_nxt : 4'd0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
      r_idx   <= 4'd0;
      r_cnt   <= 4'd0;
      r_stim  <= 4'd0;
      r_err   <= '0;
      r_fvld  <= 1'b0;
      r_fvec  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stim  <= w_stim_nxt;
      r_err   <= w_err_nxt;
      r_fvld  <= w_fvld_nxt;
      r_fvec  <= w_fvec_nxt;
    end
  end

  assign {A1, A2, A3, B} = r_stim;
  assign BUSY     = (r_state == StSettle) || (r_state == StSample);
  assign DONE     = (r_state == StDone);
  assign PASS     = DONE && (r_err == '0);
  assign ERR_CNT  = r_err;
  assign FAIL_VLD = r_fvld;
  assign FAIL_VEC = r_fvec;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__oai31_exerciser.md
GF180MCU_FD_SC_MCU9T5V0__OAI31_EXERCISER -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__oai31_exerciser

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles each vector is held before ZN is sampled; legal range 1..15.
REQ-002 SHALL have parameter ERR_W, default 8: width of the mismatch counter.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port START, input, 1: sweep request, sampled only in IDLE and DONE.
REQ-006 SHALL have port ZN, input, 1: response from the OAI31 cell under test.
REQ-007 SHALL have ports A1, A2, A3, B, output, 1 each: stimulus to the cell under test, all driven from registers.
REQ-008 SHALL have port BUSY, output, 1: sweep in progress.
REQ-009 SHALL have port DONE, output, 1: sweep complete, results valid.
REQ-010 SHALL have port PASS, output, 1: equals DONE AND ERR_CNT==0.
REQ-011 SHALL have port ERR_CNT, output, ERR_W: saturating count of mismatches.
REQ-012 SHALL have port FAIL_VLD, output, 1: at least one mismatch recorded in this sweep.
REQ-013 SHALL have port FAIL_VEC, output, 4: index of the first mismatching vector.
REQ-014 SHALL have ports VDD and VSS, inout, 1 each: supply pins, functionally unused.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-016 SHALL drive A1/A2/A3/B from vector index IDX[3:0] as {A1,A2,A3,B}=IDX (A1 is the MSB) in SETTLE and SAMPLE, and drive all four low in IDLE and DONE.
REQ-017 IDLE or DONE with START=1 at an edge SHALL clear IDX, ERR_CNT, FAIL_VLD and FAIL_VEC, load the settle counter with SETTLE_CYCLES, and enter SETTLE.
REQ-018 SETTLE SHALL decrement the settle counter each cycle and enter SAMPLE on the edge where it reaches 1, so SETTLE lasts exactly SETTLE_CYCLES cycles.
REQ-019 SAMPLE SHALL last one cycle and compare ZN against the expected value ~((A1|A2|A3)&B); any ZN not equal to the expected value, including X/Z, SHALL count as a mismatch.
REQ-020 On a mismatch, ERR_CNT SHALL increment and saturate at 2^ERR_W-1; if FAIL_VLD=0, FAIL_VEC SHALL load IDX and FAIL_VLD SHALL set.
REQ-021 SAMPLE with IDX!=15 SHALL increment IDX, reload the settle counter and enter SETTLE; SAMPLE with IDX==15 SHALL enter DONE.
REQ-022 Sweep latency SHALL be 16*(SETTLE_CYCLES+1) cycles from the START edge to the edge where DONE asserts.
REQ-023 BUSY SHALL be 1 exactly in SETTLE and SAMPLE; DONE SHALL be 1 exactly in DONE.
REQ-024 START SHALL be ignored while BUSY=1.
REQ-025 ERR_CNT, FAIL_VLD and FAIL_VEC SHALL hold their values in DONE until a new START or RST.

Reset
REQ-026 RST=1 at an edge SHALL, from any state including mid-sweep, force IDLE, set IDX=0 and the settle counter to 0, drive A1=A2=A3=B=0, and clear BUSY, DONE, PASS, ERR_CNT, FAIL_VLD and FAIL_VEC.
REQ-027 RST SHALL take priority over START when both are 1 at the same edge.

Verification
REQ-028 Ideal OAI31 model on ZN, SETTLE_CYCLES=2, one-cycle START pulse -> DONE=1 exactly 48 cycles later; PASS=1, ERR_CNT=0, FAIL_VLD=0.
REQ-029 ZN stuck at 1 -> mismatches at IDX 3,5,7,9,11,13,15; ERR_CNT=7, FAIL_VEC=3, FAIL_VLD=1, PASS=0.
REQ-030 ERR_W=2, ZN stuck at 0 -> 9 mismatches; ERR_CNT saturates at 3; FAIL_VEC=0.
REQ-031 START held high for the whole sweep -> exactly one sweep runs; a second sweep starts on the first edge in DONE, with results cleared.
REQ-032 RST pulsed while IDX=7 in SETTLE -> on the next edge: IDLE, all stimulus outputs 0, BUSY=0, ERR_CNT=0; a following START runs a full 16-vector sweep.
REQ-033 ZN driven X at IDX=10 only, model otherwise ideal -> ERR_CNT=1, FAIL_VEC=10.
